// File: rtl/par2ser_shifter_pkg.sv
// Shared types and helpers for the parallel-to-serial converter.
package par2ser_shifter_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result++;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/par2ser_shifter.sv
// Parallel-to-serial converter with a one-word holding buffer so consecutive
// words stream with no idle bit between them.
module par2ser_shifter
  import par2ser_shifter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  DIN_VALID,
  output logic                  DIN_READY,
  output logic                  SOUT,
  output logic                  SOUT_VALID,
  output logic                  SOUT_SOF,
  output logic                  SOUT_EOF,
  output logic                  BUSY
);

  localparam int unsigned    CntW    = clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   sr_q, sr_d, sr_shift;
  logic [DATA_WIDTH-1:0]   pend_q, pend_d;
  logic                    pend_full_q, pend_full_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    accept;

  logic sout_d, sout_valid_d, sof_d, eof_d, busy_d;
  logic sout_q, sout_valid_q, sof_q, eof_q, busy_q;

  // Ready depends only on reset and registered state, never on DIN_VALID.
  assign DIN_READY = RST & ~pend_full_q;
  assign accept    = DIN_VALID & DIN_READY;

  always_comb begin
    if (MSB_FIRST) begin
      sr_shift = {sr_q[DATA_WIDTH-2:0], 1'b0};
    end else begin
      sr_shift = {1'b0, sr_q[DATA_WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sr_d    = DIN;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q == CntLast) begin
          if (pend_full_q) begin
            sr_d        = pend_q;
            pend_full_d = 1'b0;
            cnt_d       = '0;
          end else if (accept) begin
            // Bypass the buffer: the new word follows EOF directly.
            sr_d  = DIN;
            cnt_d = '0;
          end else begin
            sr_d    = sr_shift;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end else begin
          sr_d  = sr_shift;
          cnt_d = cnt_q + CntW'(1);
          if (accept) begin
            pend_d      = DIN;
            pend_full_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next state so they describe the bit on the wire.
  always_comb begin
    sout_valid_d = (state_d == StShift);
    sout_d       = sout_valid_d & (MSB_FIRST ? sr_d[DATA_WIDTH-1] : sr_d[0]);
    sof_d        = sout_valid_d & (cnt_d == '0);
    eof_d        = sout_valid_d & (cnt_d == CntLast);
    busy_d       = sout_valid_d | pend_full_d;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      sr_q         <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      cnt_q        <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      cnt_q        <= cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      busy_q       <= busy_d;
    end
  end

  assign SOUT       = sout_q;
  assign SOUT_VALID = sout_valid_q;
  assign SOUT_SOF   = sof_q;
  assign SOUT_EOF   = eof_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_par2ser_shifter.sv
// Scoreboard bench: drivers push the expected bit stream of each word, monitors
// pop and compare whenever the DUT presents a valid bit.
module tb_par2ser_shifter;

  logic        clk;
  logic        rst_n;
  logic [11:0] din_a;
  logic        vld_a, rdy_a, sa, va, sofa, eofa, busy_a;
  logic [31:0] din_b;
  logic        vld_b, rdy_b, sb, vb, sofb, eofb, busy_b;

  int total = 0;
  int bad   = 0;

  logic [2:0] q_a[$];
  logic [2:0] q_b[$];
  logic [2:0] e_a, e_b;
  int run_a = 0, last_run_a = 0;
  int run_b = 0, last_run_b = 0;

  par2ser_shifter #(.DATA_WIDTH(12), .MSB_FIRST(1'b0)) dut_a (
    .CLK(clk), .RST(rst_n), .DIN(din_a), .DIN_VALID(vld_a), .DIN_READY(rdy_a),
    .SOUT(sa), .SOUT_VALID(va), .SOUT_SOF(sofa), .SOUT_EOF(eofa), .BUSY(busy_a)
  );

  par2ser_shifter #(.DATA_WIDTH(32), .MSB_FIRST(1'b1)) dut_b (
    .CLK(clk), .RST(rst_n), .DIN(din_b), .DIN_VALID(vld_b), .DIN_READY(rdy_b),
    .SOUT(sb), .SOUT_VALID(vb), .SOUT_SOF(sofb), .SOUT_EOF(eofb), .BUSY(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: entries are {sout, sof, eof}.
  always @(negedge clk) begin
    if (va) begin
      run_a++;
      if (q_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected_bit: got valid=1 expected valid=0");
      end else begin
        e_a = q_a.pop_front();
        check("a_bit", {29'b0, sa, sofa, eofa}, {29'b0, e_a});
      end
    end else begin
      if (run_a != 0) last_run_a = run_a;
      run_a = 0;
      check("a_idle_zero", {29'b0, sa, sofa, eofa}, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (vb) begin
      run_b++;
      if (q_b.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected_bit: got valid=1 expected valid=0");
      end else begin
        e_b = q_b.pop_front();
        check("b_bit", {29'b0, sb, sofb, eofb}, {29'b0, e_b});
      end
    end else begin
      if (run_b != 0) last_run_b = run_b;
      run_b = 0;
      check("b_idle_zero", {29'b0, sb, sofb, eofb}, 32'd0);
    end
  end

  // stream[i] is the i-th bit expected on the wire.
  task automatic send_a(input logic [11:0] w, input logic [11:0] stream);
    int n = 0;
    din_a = w;
    vld_a = 1'b1;
    while (!rdy_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL a_ready_timeout: got ready=0 expected ready=1");
      vld_a = 1'b0;
      return;
    end
    for (int i = 0; i < 12; i++) q_a.push_back({stream[i], i == 0, i == 11});
    @(negedge clk);
    vld_a = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] w, input logic [31:0] stream);
    int n = 0;
    din_b = w;
    vld_b = 1'b1;
    while (!rdy_b && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL b_ready_timeout: got ready=0 expected ready=1");
      vld_b = 1'b0;
      return;
    end
    for (int i = 0; i < 32; i++) q_b.push_back({stream[i], i == 0, i == 31});
    @(negedge clk);
    vld_b = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || va || vb) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, {31'b0, n < 500}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    din_a = 12'hFFF;
    din_b = 32'hFFFF_FFFF;
    vld_a = 1'b1;
    vld_b = 1'b1;

    // Reset held with valid asserted.
    repeat (3) @(negedge clk);
    check("rst_a_outputs", {27'b0, sa, va, sofa, eofa, busy_a}, 32'd0);
    check("rst_b_outputs", {27'b0, sb, vb, sofb, eofb, busy_b}, 32'd0);
    check("rst_a_ready", {31'b0, rdy_a}, 32'd0);
    check("rst_b_ready", {31'b0, rdy_b}, 32'd0);
    rst_n = 1'b1;
    vld_a = 1'b0;
    vld_b = 1'b0;
    @(negedge clk);
    check("post_rst_a_ready", {31'b0, rdy_a}, 32'd1);
    check("post_rst_b_ready", {31'b0, rdy_b}, 32'd1);

    // Single word, LSB first: 0,0,1,1,1,0,1,0,0,1,0,1.
    send_a(12'hA5C, 12'b1010_0101_1100);
    drain("single");
    check("single_run", last_run_a, 32'd12);
    check("single_busy", {31'b0, busy_a}, 32'd0);
    check("single_valid", {31'b0, va}, 32'd0);

    // Back-to-back with valid effectively held high.
    send_a(12'hFFF, 12'hFFF);
    send_a(12'h000, 12'h000);
    check("b2b_ready_low1", {31'b0, rdy_a}, 32'd0);
    check("b2b_busy1", {31'b0, busy_a}, 32'd1);
    send_a(12'h801, 12'h801);
    check("b2b_ready_low2", {31'b0, rdy_a}, 32'd0);
    drain("b2b");
    check("b2b_run", last_run_a, 32'd36);

    // Bypass: new word offered exactly on EOF with the buffer empty.
    send_a(12'h3C5, 12'h3C5);
    n = 0;
    while (!eofa && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bypass_eof_seen", {31'b0, eofa}, 32'd1);
    check("bypass_ready_at_eof", {31'b0, rdy_a}, 32'd1);
    din_a = 12'h001;
    vld_a = 1'b1;
    for (int i = 0; i < 12; i++) q_a.push_back({i == 0, i == 0, i == 11});
    @(negedge clk);
    vld_a = 1'b0;
    check("bypass_sof", {30'b0, va, sofa}, 32'd3);
    check("bypass_no_pend", {31'b0, rdy_a}, 32'd1);
    drain("bypass");
    check("bypass_run", last_run_a, 32'd24);

    // MSB first, 32 bits: 1, thirty 0s, 1; then four 1s and zeros.
    send_b(32'h8000_0001, 32'h8000_0001);
    send_b(32'hF000_0000, 32'h0000_000F);
    drain("msb");
    check("msb_run", last_run_b, 32'd64);

    // Reset mid-word with a word pending.
    send_a(12'hABC, 12'hABC);
    send_a(12'h123, 12'h123);
    check("mid_pend_full", {31'b0, rdy_a}, 32'd0);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    q_a.delete();
    #1;
    check("mid_rst_outputs", {26'b0, sa, va, sofa, eofa, busy_a, rdy_a}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("mid_no_resume_busy", {31'b0, busy_a}, 32'd0);
    check("mid_ready", {31'b0, rdy_a}, 32'd1);

    check("final_q_a_empty", q_a.size(), 32'd0);
    check("final_q_b_empty", q_b.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
